cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, meaning log2 of line count (64 direct-mapped one-word lines).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MemRead  input  1  datapath load request.
REQ-006 SHALL have port MemWrite  input  1  datapath store request.
REQ-007 SHALL have port Address  input  ADDR_W  datapath byte address (ALUResult).
REQ-008 SHALL have port WriteData  input  32  store data.
REQ-009 SHALL have port Read_Data  output  32  load data to datapath.
REQ-010 SHALL have port stall  output  1  freezes the datapath PC while high.
REQ-011 SHALL have port mem_req  output  1  main-memory request.
REQ-012 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-013 SHALL have port mem_addr  output  ADDR_W  word-aligned address {addr[31:2],2'b00}.
REQ-014 SHALL have port mem_wdata  output  32  store data to memory.
REQ-015 SHALL have port mem_rdata  input  32  memory read data, valid with mem_ready.
REQ-016 SHALL have port mem_ready  input  1  one-cycle completion pulse from memory.
REQ-017 SHALL have ports hit_count and miss_count  output  32 each  access statistics.

Function
REQ-018 Address split SHALL be: offset [1:0] ignored, index [INDEX_W+1:2], tag [ADDR_W-1:INDEX_W+2].
REQ-019 FSM states SHALL be IDLE, MEM_READ, MEM_WRITE, WDONE.
REQ-020 Hit SHALL mean valid[index]=1 and tag[index]=Address tag; Read_Data SHALL combinationally equal data[index] in IDLE.
REQ-021 IDLE read hit: stall=0, no memory traffic, state stays IDLE.
REQ-022 IDLE read miss: stall=1 combinationally same cycle; latch word address; next state MEM_READ.
REQ-023 MEM_READ: mem_req=1, mem_we=0, stall=1; on mem_ready write valid/tag/mem_rdata into line, next state IDLE, where the access then hits and stall drops.
REQ-024 IDLE with MemWrite (hit or miss): stall=1; latch address and WriteData; next state MEM_WRITE.
REQ-025 MEM_WRITE: mem_req=1, mem_we=1, stall=1; on mem_ready update data[index] only if the line hits (write-through, no-write-allocate), next state WDONE.
REQ-026 WDONE: stall=0, mem_req=0 for exactly one cycle so the store retires; next state IDLE.
REQ-027 MemRead and MemWrite both high SHALL be treated as a write.
REQ-028 mem_addr/mem_wdata SHALL come from latched registers and SHALL hold constant while mem_req=1, regardless of Address changes.
REQ-029 mem_ready outside MEM_READ/MEM_WRITE SHALL be ignored.
REQ-030 Memory latency SHALL be unbounded; controller waits indefinitely in MEM_READ/MEM_WRITE.
REQ-031 Stall cycles: read miss = L+1, store = L+1, where L = cycles from mem_req rise to mem_ready inclusive.
REQ-032 hit_count SHALL increment on an IDLE read hit not immediately following MEM_READ; miss_count on each IDLE to MEM_READ transition; stores counted in neither; both saturate at 32'hFFFFFFFF.

Reset
REQ-033 reset low SHALL immediately force state IDLE, clear all valid bits, clear both counters, drop mem_req/mem_we to 0, and zero latched address/data.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer without writing the line; a later mem_ready SHALL be ignored.
REQ-035 After reset, stall SHALL be 0 unless MemRead or MemWrite is high (first read always misses).

Structure
REQ-036 State encoding, INDEX_W/TAG_W derivation and line-count constant SHALL live in shared package cache_pkg.
REQ-037 Valid/tag/data arrays SHALL be sub-module cache_mem (async-read, sync-write, async valid clear); FSM, latches and counters SHALL reside in cache_controller.

Verification
REQ-038 Reset, read 0x100, mem_ready after 3 cycles with 0xDEADBEEF -> stall high 4 cycles, Read_Data=0xDEADBEEF, miss_count=1.
REQ-039 Repeat read 0x100 -> stall=0 same cycle, no mem_req, hit_count=1.
REQ-040 Store 0x55 to 0x100 (hit), ready after 2 cycles -> mem_we=1, mem_addr=0x100, one WDONE cycle, later read 0x100 returns 0x55 with no miss.
REQ-041 Store to 0x200 (miss), then read 0x200 -> memory write issued, line not allocated, read misses (miss_count increments).
REQ-042 Read 0x104 then 0x504 (same index, different tag) -> second read misses and replaces line; read 0x104 misses again.
REQ-043 Assert reset during MEM_READ, then pulse mem_ready -> mem_req drops immediately, stall=0, line stays invalid, counters 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache:
// controller states, default geometry and address-field width helpers.
package cache_pkg;

   localparam int INDEX_W_DEF = 6;
   localparam int ADDR_W_DEF  = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2,
      WDONE     = 2'd3
   } cache_state_e;

   // Tag is whatever remains above the line index and the 2-bit byte offset.
   function automatic int tag_width(input int addr_w, input int index_w);
      return addr_w - index_w - 2;
   endfunction

   function automatic int line_count(input int index_w);
      return 1 << index_w;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/cache_mem.sv
// Line storage: valid bits (async clear), tags and one data word per line.
// Reads are combinational, writes happen on the rising clock edge.
module cache_mem
   import cache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int TAG_W   = ADDR_W_DEF - INDEX_W_DEF - 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [INDEX_W-1:0] rd_index_i,
   output logic               rd_valid_o,
   output logic [TAG_W-1:0]   rd_tag_o,
   output logic [31:0]        rd_data_o,
   input  logic               we_i,
   input  logic [INDEX_W-1:0] wr_index_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [31:0]        wr_data_i
);

   localparam int NUM_LINES = line_count(INDEX_W);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [31:0]          data_q [NUM_LINES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_index_i] <= 1'b1;
      end
   end

   // Tag/data need no reset: a cleared valid bit masks whatever they hold.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[wr_index_i]  <= wr_tag_i;
         data_q[wr_index_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-through / no-write-allocate cache controller that
// stalls the datapath while a line fill or a store is outstanding.
module cache_controller
   import cache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Address,
   input  logic [31:0]       WriteData,
   output logic [31:0]       Read_Data,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count,
   output cache_state_e      dbg_state
);

   localparam int TAG_W  = tag_width(ADDR_W, INDEX_W);
   localparam int WORD_W = ADDR_W - 2;

   cache_state_e      state_q;
   logic [WORD_W-1:0] waddr_q;
   logic [31:0]       wdata_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic              after_fill_q;
   logic [31:0]       hit_q;
   logic [31:0]       miss_q;

   logic [WORD_W-1:0] req_word;
   logic [WORD_W-1:0] look_word;
   logic              line_valid;
   logic [TAG_W-1:0]  line_tag;
   logic [31:0]       line_data;
   logic              hit;
   logic              fill;
   logic              line_we;
   logic              unused_offset;

   assign req_word      = Address[ADDR_W-1:2];
   assign unused_offset = ^Address[1:0];

   // Idle lookups use the live address; in-flight stores check the latched one.
   assign look_word = (state_q == IDLE) ? req_word : waddr_q;
   assign hit       = line_valid && (line_tag == look_word[WORD_W-1:INDEX_W]);
   assign fill      = (state_q == MEM_READ) && mem_ready;
   assign line_we   = fill || ((state_q == MEM_WRITE) && mem_ready && hit);

   cache_mem #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_mem (
      .clk_i      (clk),
      .rst_ni     (reset),
      .rd_index_i (look_word[INDEX_W-1:0]),
      .rd_valid_o (line_valid),
      .rd_tag_o   (line_tag),
      .rd_data_o  (line_data),
      .we_i       (line_we),
      .wr_index_i (waddr_q[INDEX_W-1:0]),
      .wr_tag_i   (waddr_q[WORD_W-1:INDEX_W]),
      .wr_data_i  (fill ? mem_rdata : wdata_q)
   );

   always_comb begin
      stall = 1'b0;
      case (state_q)
         IDLE:                stall = MemWrite | (MemRead & ~hit);
         MEM_READ, MEM_WRITE: stall = 1'b1;
         default:             stall = 1'b0;
      endcase
   end

   // Memory handshake: mem_req rises with address/data already latched and
   // stays high, unchanged, until the single-cycle mem_ready pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         waddr_q      <= '0;
         wdata_q      <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         after_fill_q <= 1'b0;
         hit_q        <= '0;
         miss_q       <= '0;
      end else begin
         after_fill_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (MemWrite) begin
                  state_q   <= MEM_WRITE;
                  waddr_q   <= req_word;
                  wdata_q   <= WriteData;
                  mem_req_q <= 1'b1;
                  mem_we_q  <= 1'b1;
               end else if (MemRead && !hit) begin
                  state_q   <= MEM_READ;
                  waddr_q   <= req_word;
                  mem_req_q <= 1'b1;
                  mem_we_q  <= 1'b0;
                  miss_q    <= sat_inc(miss_q);
               end else if (MemRead && !after_fill_q) begin
                  hit_q <= sat_inc(hit_q);
               end
            end
            MEM_READ: begin
               if (mem_ready) begin
                  state_q      <= IDLE;
                  mem_req_q    <= 1'b0;
                  after_fill_q <= 1'b1;
               end
            end
            MEM_WRITE: begin
               if (mem_ready) begin
                  state_q   <= WDONE;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Read_Data  = line_data;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = {waddr_q, 2'b00};
   assign mem_wdata  = wdata_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a table of accesses with hand-computed
// stall counts, data and counters, plus hand sequences for transfer corners.
module tb_cache_controller;
   import cache_pkg::*;

   localparam logic [1:0] OP_RD = 2'd0;
   localparam logic [1:0] OP_WR = 2'd1;
   localparam logic [1:0] OP_RW = 2'd2;

   logic         clk;
   logic         reset;
   logic         MemRead;
   logic         MemWrite;
   logic [31:0]  Address;
   logic [31:0]  WriteData;
   logic [31:0]  Read_Data;
   logic         stall;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;
   logic         mem_ready;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;
   cache_state_e dbg_state;

   cache_controller #(.INDEX_W(6), .ADDR_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Address    (Address),
      .WriteData  (WriteData),
      .Read_Data  (Read_Data),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .dbg_state  (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] rdata;
      int          exp_stall;
      logic        exp_req;
      logic [31:0] exp_rd;
      int          exp_hits;
      int          exp_misses;
   } vec_t;

   localparam int NV = 16;
   vec_t        vecs [NV];
   logic [31:0] exp_q [$];
   int          n_checks = 0;
   int          n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one table access from a negedge and plays the memory side.
   task automatic run_access(input int idx);
      vec_t v;
      int   stalls;
      int   rcyc;
      int   guard;
      logic seen_req;
      v = vecs[idx];
      MemRead   = (v.op != OP_WR);
      MemWrite  = (v.op != OP_RD);
      Address   = v.addr;
      WriteData = v.wdata;
      if (v.exp_req) exp_q.push_back({v.addr[31:2], 2'b00});
      stalls   = 0;
      rcyc     = 0;
      guard    = 0;
      seen_req = 1'b0;
      #1;
      while (stall === 1'b1 && guard < 200) begin
         stalls++;
         guard++;
         if (mem_req === 1'b1) begin
            if (!seen_req && v.exp_req && exp_q.size() > 0) begin
               check($sformatf("v%0d mem_addr", idx), mem_addr, exp_q.pop_front());
               check($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.op != OP_RD));
               if (v.op != OP_RD) check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
            end
            seen_req = 1'b1;
            rcyc++;
            if (rcyc == v.lat) begin
               mem_ready = 1'b1;
               mem_rdata = v.rdata;
            end
         end
         @(negedge clk);
         mem_ready = 1'b0;
         #1;
      end
      if (guard >= 200) check($sformatf("v%0d stall_timeout", idx), 32'(guard), 32'd0);
      check($sformatf("v%0d stall_cycles", idx), 32'(stalls), 32'(v.exp_stall));
      check($sformatf("v%0d mem_req_seen", idx), 32'(seen_req), 32'(v.exp_req));
      if (v.op == OP_RD) check($sformatf("v%0d read_data", idx), Read_Data, v.exp_rd);
      @(negedge clk);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      #1;
      check($sformatf("v%0d mem_req_idle", idx), 32'(mem_req), 32'd0);
      check($sformatf("v%0d hit_count", idx), hit_count, 32'(v.exp_hits));
      check($sformatf("v%0d miss_count", idx), miss_count, 32'(v.exp_misses));
   endtask

   initial begin
      //            op     addr           wdata          lat rdata          stl req exp_rd         hit miss
      vecs[0]  = '{OP_RD, 32'h0000_0100, 32'h0,         3, 32'hDEAD_BEEF, 4, 1, 32'hDEAD_BEEF, 0, 1};
      vecs[1]  = '{OP_RD, 32'h0000_0100, 32'h0,         0, 32'h0,         0, 0, 32'hDEAD_BEEF, 1, 1};
      vecs[2]  = '{OP_WR, 32'h0000_0100, 32'h0000_0055, 2, 32'h0,         3, 1, 32'h0,         1, 1};
      vecs[3]  = '{OP_RD, 32'h0000_0100, 32'h0,         0, 32'h0,         0, 0, 32'h0000_0055, 2, 1};
      vecs[4]  = '{OP_WR, 32'h0000_0200, 32'hA5A5_0001, 1, 32'h0,         2, 1, 32'h0,         2, 1};
      vecs[5]  = '{OP_RD, 32'h0000_0200, 32'h0,         2, 32'h2222_0000, 3, 1, 32'h2222_0000, 2, 2};
      vecs[6]  = '{OP_RD, 32'h0000_0104, 32'h0,         1, 32'h1111_1104, 2, 1, 32'h1111_1104, 2, 3};
      vecs[7]  = '{OP_RD, 32'h0000_0504, 32'h0,         4, 32'h5555_0504, 5, 1, 32'h5555_0504, 2, 4};
      vecs[8]  = '{OP_RD, 32'h0000_0104, 32'h0,         2, 32'h1111_AAAA, 3, 1, 32'h1111_AAAA, 2, 5};
      vecs[9]  = '{OP_RD, 32'h0000_0106, 32'h0,         0, 32'h0,         0, 0, 32'h1111_AAAA, 3, 5};
      vecs[10] = '{OP_RD, 32'h0000_0200, 32'h0,         0, 32'h0,         0, 0, 32'h2222_0000, 4, 5};
      vecs[11] = '{OP_RW, 32'h0000_0200, 32'h0000_0077, 1, 32'h0,         2, 1, 32'h0,         4, 5};
      vecs[12] = '{OP_RD, 32'h0000_0200, 32'h0,         0, 32'h0,         0, 0, 32'h0000_0077, 5, 5};
      vecs[13] = '{OP_WR, 32'h0000_020F, 32'h0C0C_0C0C, 3, 32'h0,         4, 1, 32'h0,         5, 5};
      vecs[14] = '{OP_RD, 32'hFFFF_FFFC, 32'h0,         1, 32'h0BAD_F00D, 2, 1, 32'h0BAD_F00D, 5, 6};
      vecs[15] = '{OP_RD, 32'hFFFF_FFFE, 32'h0,         0, 32'h0,         0, 0, 32'h0BAD_F00D, 6, 6};

      reset     = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = '0;
      WriteData = '0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst stall", 32'(stall), 32'd0);
      check("rst mem_req", 32'(mem_req), 32'd0);
      check("rst mem_we", 32'(mem_we), 32'd0);
      check("rst mem_addr", mem_addr, 32'd0);
      check("rst mem_wdata", mem_wdata, 32'd0);
      check("rst hit_count", hit_count, 32'd0);
      check("rst miss_count", miss_count, 32'd0);
      check("rst state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("post_rst stall", 32'(stall), 32'd0);

      @(negedge clk);
      for (int i = 0; i < NV; i++) run_access(i);

      // Address wanders while a fill is outstanding; the request must not.
      MemRead = 1'b1;
      Address = 32'h0000_0300;
      #1;
      check("hold stall_idle", 32'(stall), 32'd1);
      @(negedge clk);
      Address = 32'h1234_5678;
      #1;
      check("hold mem_req", 32'(mem_req), 32'd1);
      check("hold mem_addr1", mem_addr, 32'h0000_0300);
      check("hold mem_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      #1;
      check("hold mem_addr2", mem_addr, 32'h0000_0300);
      check("hold stall", 32'(stall), 32'd1);
      mem_ready = 1'b1;
      mem_rdata = 32'h3030_3030;
      @(negedge clk);
      mem_ready = 1'b0;
      Address   = 32'h0000_0300;
      #1;
      check("hold stall_done", 32'(stall), 32'd0);
      check("hold read_data", Read_Data, 32'h3030_3030);
      @(negedge clk);
      MemRead = 1'b0;
      #1;
      check("hold miss_count", miss_count, 32'd7);
      check("hold hit_count", hit_count, 32'd6);

      // Stray mem_ready with nothing outstanding.
      mem_ready = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("stray mem_req", 32'(mem_req), 32'd0);
      check("stray state", 32'(dbg_state), 32'(IDLE));
      MemRead = 1'b1;
      Address = 32'h0000_0300;
      #1;
      check("stray stall", 32'(stall), 32'd0);
      check("stray read_data", Read_Data, 32'h3030_3030);
      @(negedge clk);
      MemRead = 1'b0;
      #1;
      check("stray hit_count", hit_count, 32'd7);

      // Reset in the middle of a fill, then late mem_ready pulses.
      MemRead = 1'b1;
      Address = 32'h0000_0400;
      @(negedge clk);
      #1;
      check("abort mem_req_before", 32'(mem_req), 32'd1);
      @(negedge clk);
      MemRead = 1'b0;
      reset   = 1'b0;
      #1;
      check("abort mem_req", 32'(mem_req), 32'd0);
      check("abort mem_we", 32'(mem_we), 32'd0);
      check("abort stall", 32'(stall), 32'd0);
      check("abort state", 32'(dbg_state), 32'(IDLE));
      check("abort mem_addr", mem_addr, 32'd0);
      check("abort hit_count", hit_count, 32'd0);
      check("abort miss_count", miss_count, 32'd0);
      mem_ready = 1'b1;
      mem_rdata = 32'h4444_4444;
      @(negedge clk);
      mem_ready = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("late mem_req", 32'(mem_req), 32'd0);
      check("late state", 32'(dbg_state), 32'(IDLE));
      check("late hit_count", hit_count, 32'd0);
      check("late miss_count", miss_count, 32'd0);
      MemRead = 1'b1;
      Address = 32'h0000_0400;
      #1;
      check("late line_0x400_invalid", 32'(stall), 32'd1);
      Address = 32'h0000_0300;
      #1;
      check("late line_0x300_invalid", 32'(stall), 32'd1);
      MemRead = 1'b0;
      #1;
      check("late stall_quiet", 32'(stall), 32'd0);

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
